// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants for the MIPS datapath: register-file geometry and the
// architectural register numbers that the decoder and the benches refer to.
package mips_pkg;

    localparam int         REG_AW   = 5;
    localparam int         DATA_W   = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Architectural register names
    localparam logic [4:0] REG_AT = 5'd1;
    localparam logic [4:0] REG_V0 = 5'd2;
    localparam logic [4:0] REG_A0 = 5'd4;
    localparam logic [4:0] REG_T0 = 5'd8;
    localparam logic [4:0] REG_S0 = 5'd16;
    localparam logic [4:0] REG_GP = 5'd28;
    localparam logic [4:0] REG_SP = 5'd29;
    localparam logic [4:0] REG_FP = 5'd30;
    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/reg_en_32b.sv
// reg_en_32b
// One WIDTH-bit storage register with a load enable and an asynchronous
// active-low clear.
//   clk   : rising-edge clock
//   rst_n : async active-low clear, Q -> 0
//   en    : load D on the next rising edge
//   D     : data in
//   Q     : stored value
module reg_en_32b #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  Q <= '0;
        else if (en) Q <= D;
    end

endmodule

// File: rtl/mips_reg_file.sv
// mips_reg_file
// 2**AW x WIDTH MIPS general-purpose register file: two combinational read
// ports (rs/rt -> ALU operands A/B) and one synchronous write port.
// Register 0 has no storage and always reads zero.
//   clk, rst_n          : clock, async active-low clear of every register
//   RegWrite/WriteReg/WriteData : write port, takes effect on posedge clk
//   ReadReg1/ReadData1  : read port 1 (rs -> operand A)
//   ReadReg2/ReadData2  : read port 2 (rt -> operand B)
// BYPASS=1 forwards WriteData to a port reading the register that is being
// written in the same cycle; BYPASS=0 returns the pre-edge contents.
module mips_reg_file
    import mips_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int AW     = REG_AW,
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegWrite,
    input  logic [AW-1:0]    WriteReg,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [AW-1:0]    ReadReg1,
    input  logic [AW-1:0]    ReadReg2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam int NREG = 2 ** AW;

    // regs[0] is a constant zero so the read mux needs no special case for $zero.
    logic [NREG-1:0][WIDTH-1:0] regs;

    assign regs[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic wr_en;
        assign wr_en = RegWrite && (WriteReg == AW'(i));

        reg_en_32b #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (wr_en),
            .D     (WriteData),
            .Q     (regs[i])
        );
    end

    // A write to $zero never forwards, and nothing forwards while in reset
    // so that both ports read zero for the whole reset window.
    logic wr_live;
    assign wr_live = BYPASS && rst_n && RegWrite && (WriteReg != AW'(REG_ZERO));

    always_comb begin
        ReadData1 = regs[ReadReg1];
        ReadData2 = regs[ReadReg2];
        if (wr_live && (WriteReg == ReadReg1)) ReadData1 = WriteData;
        if (wr_live && (WriteReg == ReadReg2)) ReadData2 = WriteData;
    end

endmodule

// File: tb/tb_mips_reg_file.sv
module tb_mips_reg_file;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  wa = '0, r1 = '0, r2 = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;

    always #5 clk = ~clk;

    // Same stimulus into a non-bypassing and a bypassing instance.
    mips_reg_file #(.WIDTH(32), .AW(5), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .RegWrite(we), .WriteReg(wa), .WriteData(wd),
        .ReadReg1(r1), .ReadReg2(r2), .ReadData1(rd1_a), .ReadData2(rd2_a));

    mips_reg_file #(.WIDTH(32), .AW(5), .BYPASS(1'b1)) dut_bp (
        .clk(clk), .rst_n(rst_n), .RegWrite(we), .WriteReg(wa), .WriteData(wd),
        .ReadReg1(r1), .ReadReg2(r2), .ReadData1(rd1_b), .ReadData2(rd2_b));

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [32];

    // e1/e2: expected pre-edge reads without bypass, b1/b2: with bypass
    typedef struct {
        logic [31:0] e1, e2, b1, b2;
    } exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1, r2;
        logic [31:0] e1, e2, b1, b2;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model_exp(input logic w, input logic [4:0] a, input logic [31:0] d,
                                       input logic [4:0] ra, input logic [4:0] rb);
        exp_t e;
        e.e1 = (ra == 5'd0) ? 32'h0 : mdl[ra];
        e.e2 = (rb == 5'd0) ? 32'h0 : mdl[rb];
        e.b1 = (w && a != 5'd0 && a == ra) ? d : e.e1;
        e.b2 = (w && a != 5'd0 && a == rb) ? d : e.e2;
        return e;
    endfunction

    // One clock: drive at negedge, check the combinational reads before the
    // edge, then let the edge happen and update the model.
    task automatic drive_cycle(input logic w, input logic [4:0] a, input logic [31:0] d,
                               input logic [4:0] ra, input logic [4:0] rb,
                               input exp_t e, input string nm);
        exp_t x;
        @(negedge clk);
        we = w; wa = a; wd = d; r1 = ra; r2 = rb;
        sb.push_back(e);
        #1;
        x = sb.pop_front();
        chk({nm, ".nb1"}, rd1_a, x.e1);
        chk({nm, ".nb2"}, rd2_a, x.e2);
        chk({nm, ".bp1"}, rd1_b, x.b1);
        chk({nm, ".bp2"}, rd2_b, x.b2);
        @(posedge clk);
        if (w && a != 5'd0 && rst_n) mdl[a] = d;
    endtask

    task automatic model_cycle(input logic w, input logic [4:0] a, input logic [31:0] d,
                               input logic [4:0] ra, input logic [4:0] rb, input string nm);
        drive_cycle(w, a, d, ra, rb, model_exp(w, a, d, ra, rb), nm);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

        //         we    wa      wd            r1     r2     e1            e2            b1            b2
        vecs[0]  = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd0,  32'h0,        32'h0,        32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd8,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[4]  = '{1'b1, 5'd3,  32'h0000FFFF, 5'd3,  5'd4,  32'h0,        32'h0,        32'h0000FFFF, 32'h0};
        vecs[5]  = '{1'b1, 5'd4,  32'h00FF00FF, 5'd3,  5'd4,  32'h0000FFFF, 32'h0,        32'h0000FFFF, 32'h00FF00FF};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  32'h0000FFFF, 32'h00FF00FF, 32'h0000FFFF, 32'h00FF00FF};
        vecs[7]  = '{1'b1, 5'd5,  32'h1,        5'd5,  5'd5,  32'h0,        32'h0,        32'h1,        32'h1};
        vecs[8]  = '{1'b1, 5'd5,  32'h2,        5'd5,  5'd5,  32'h1,        32'h1,        32'h2,        32'h2};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'h2,        32'h2,        32'h2,        32'h2};
        vecs[10] = '{1'b1, 5'd7,  32'hAAAA5555, 5'd7,  5'd0,  32'h0,        32'h0,        32'hAAAA5555, 32'h0};
        vecs[11] = '{1'b0, 5'd7,  32'h12345678, 5'd7,  5'd7,  32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555};

        // Power-on reset, released mid-cycle.
        r1 = 5'd8; r2 = 5'd31;
        #3;
        chk("por.rd1", rd1_a, 32'h0);
        chk("por.rd2", rd2_b, 32'h0);
        #9 rst_n = 1'b1;

        // Directed table.
        for (int v = 0; v < 13; v++) begin
            exp_t e;
            e.e1 = vecs[v].e1; e.e2 = vecs[v].e2; e.b1 = vecs[v].b1; e.b2 = vecs[v].b2;
            drive_cycle(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].r1, vecs[v].r2, e,
                        $sformatf("vec%0d", v));
        end

        // Operands into the downstream AND unit.
        @(negedge clk);
        we = 1'b0; r1 = 5'd3; r2 = 5'd4;
        #1;
        chk("and.nb", rd1_a & rd2_a, 32'h000000FF);
        chk("and.bp", rd1_b & rd2_b, 32'h000000FF);

        // Walk all 31 registers with unique data, then read each back on both ports.
        for (int i = 1; i < 32; i++)
            model_cycle(1'b1, 5'(i), 32'hA5000000 ^ (32'h01010101 * 32'(i)), 5'(i), 5'(32 - i),
                        $sformatf("walkw%0d", i));
        for (int i = 1; i < 32; i++)
            model_cycle(1'b0, 5'(i), 32'h12345678, 5'(i), 5'(32 - i), $sformatf("walkr%0d", i));
        chk("walk.r7", mdl[7], 32'hA5000000 ^ (32'h01010101 * 32'd7));

        // Random traffic.
        for (int i = 0; i < 40; i++)
            model_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                        5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                        $sformatf("rnd%0d", i));

        // Async reset mid-cycle: every address reads zero immediately.
        @(negedge clk);
        we = 1'b0;
        #2 rst_n = 1'b0;
        for (int a = 0; a < 32; a++) begin
            r1 = 5'(a); r2 = 5'(31 - a);
            #1;
            chk($sformatf("rst.nb1.%0d", a), rd1_a, 32'h0);
            chk($sformatf("rst.nb2.%0d", a), rd2_a, 32'h0);
            chk($sformatf("rst.bp1.%0d", a), rd1_b, 32'h0);
            chk($sformatf("rst.bp2.%0d", a), rd2_b, 32'h0);
        end
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

        // Write pending across an edge while in reset: reset wins, no forwarding.
        @(negedge clk);
        we = 1'b1; wa = 5'd9; wd = 32'hCAFEF00D; r1 = 5'd9; r2 = 5'd9;
        #1;
        chk("rstwr.pre.nb", rd1_a, 32'h0);
        chk("rstwr.pre.bp", rd2_b, 32'h0);
        @(posedge clk);
        #1;
        chk("rstwr.post.nb", rd1_a, 32'h0);
        chk("rstwr.post.bp", rd1_b, 32'h0);

        // Release mid-cycle; the next edge performs a normal write.
        @(negedge clk);
        we = 1'b0;
        #2 rst_n = 1'b1;
        model_cycle(1'b1, 5'd9, 32'h0BADC0DE, 5'd9, 5'd0, "relwr");
        model_cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, "relrd");
        chk("relrd.model", mdl[9], 32'h0BADC0DE);

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL sb_leftover: got %0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
